mem_access_unit: RTL

- Load/store stage directly downstream of the single-cycle datapath.
- Consumes the datapath's ALUResult (address), WriteData, MemWrite and MemtoReg (load) outputs. Runs a req/ack transaction on the data-memory bus, then returns ReadData to the datapath.
- Asserts Stall so the PC register and register-file write hold while the memory is busy.
- Adds byte/word sizing with lane steering, plus sticky misalignment and timeout error flags.

---
 rtl/mem_access_pkg.sv | 21 ++
 rtl/mem_lane_align.sv | 21 ++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and byte-lane helpers for the load/store stage.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam logic [3:0]  BE_WORD   = 4'hF;
    localparam logic [31:0] ERR_RDATA = 32'h0;

    function automatic logic [3:0] be_for_byte(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [31:0] replicate_byte(input logic [7:0] b);
        return {4{b}};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Read-side steering: picks the addressed byte lane and zero-extends it.
module mem_lane_align (
    input  logic [31:0] data,
    input  logic [1:0]  lane,
    input  logic        is_byte,
    output logic [31:0] result
);

    always_comb begin
        result = data;
        if (is_byte) begin
            unique case (lane)
                2'd0:    result = {24'h0, data[7:0]};
                2'd1:    result = {24'h0, data[15:8]};
                2'd2:    result = {24'h0, data[23:16]};
                default: result = {24'h0, data[31:24]};
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: drives a req/ack data bus and stalls the core meanwhile.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        ByteAcc,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        err_align,
    output logic        err_timeout
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [1:0]  lane, lane_next;
    logic        is_byte, is_byte_next;
    logic [31:0] rdata, rdata_next;
    logic        req_next, we_next;
    logic [31:0] addr_next, wdata_next;
    logic [3:0]  be_next;
    logic        align_next, timeout_next;
    logic [31:0] lane_data;
    logic        acc, aligned;

    assign acc     = MemWrite | MemtoReg;
    assign aligned = ByteAcc | (ALUResult[1:0] == 2'b00);

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        lane_next    = lane;
        is_byte_next = is_byte;
        rdata_next   = rdata;
        req_next     = bus_req;
        we_next      = bus_we;
        addr_next    = bus_addr;
        be_next      = bus_be;
        wdata_next   = bus_wdata;
        align_next   = err_align;
        timeout_next = err_timeout;
        unique case (state)
            IDLE: begin
                if (acc && aligned) begin
                    req_next     = 1'b1;
                    we_next      = MemWrite;
                    addr_next    = {ALUResult[31:2], 2'b00};
                    be_next      = ByteAcc ? be_for_byte(ALUResult[1:0])
                                           : BE_WORD;
                    wdata_next   = ByteAcc ? replicate_byte(WriteData[7:0])
                                           : WriteData;
                    lane_next    = ALUResult[1:0];
                    is_byte_next = ByteAcc;
                    cnt_next     = 8'd0;
                    state_next   = REQ;
                end else if (acc) begin
                    align_next = 1'b1;
                    rdata_next = ERR_RDATA;
                    state_next = DONE;
                end
            end
            REQ: begin
                // ack in the expiry cycle still counts as success
                if (bus_ack) begin
                    rdata_next = bus_we ? ERR_RDATA : bus_rdata;
                    req_next   = 1'b0;
                    state_next = DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_next = 1'b1;
                    rdata_next   = ERR_RDATA;
                    req_next     = 1'b0;
                    state_next   = DONE;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            lane        <= 2'd0;
            is_byte     <= 1'b0;
            rdata       <= ERR_RDATA;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_be      <= 4'h0;
            bus_wdata   <= 32'h0;
            err_align   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            lane        <= lane_next;
            is_byte     <= is_byte_next;
            rdata       <= rdata_next;
            bus_req     <= req_next;
            bus_we      <= we_next;
            bus_addr    <= addr_next;
            bus_be      <= be_next;
            bus_wdata   <= wdata_next;
            err_align   <= align_next;
            err_timeout <= timeout_next;
        end
    end

    mem_lane_align u_align (
        .data    (rdata),
        .lane    (lane),
        .is_byte (is_byte),
        .result  (lane_data)
    );

    assign ReadData = (state == DONE) ? lane_data : ERR_RDATA;

    // reset gating keeps the core free to move while the unit is held in reset
    assign Stall = reset & (((state == IDLE) & acc) | (state == REQ));

endmodule
